frame_decoder: RTL and testbench
================================

# frame_decoder

Receive-side counterpart of the capture frame generator. Accepts the 16-bit sample stream, locks to the 512-sample frame via the 192-bit sync pattern in the top 6 bits, and recovers the ADC128 audio (12-bit L/R), PCM1802 audio (24-bit L/R) and 48-bit sequence counter. Checks counter continuity and sync integrity, and passes the 10-bit RF field through. Used for on-FPGA loopback self-test and as the reference model for host-side unpacking.

## Interface
- SYNC_PATTERN, 192'hDDDF20251015DDDF20251015DDDF20251016FEDCBA987654, sync word k (k=0..31) = SYNC_PATTERN[6k+5:6k]
- MISS_LIMIT, 2, consecutive bad-sync frames that drop lock (1..15)
- clock  in  1  sample clock; all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- dataIn  in  16  [15:10] frame field, [9:0] RF sample
- dataValid  in  1  dataIn valid this cycle; when low nothing advances
- rfOut  out  10  registered dataIn[9:0] of last valid word
- locked  out  1  frame lock held
- frameStart  out  1  pulse: word at position 0 accepted while locked
- adcLeft, adcRight  out  12 each  last recovered ADC128 pair
- adcValid  out  1  pulse: new ADC128 pair
- pcmLeft, pcmRight  out  24 each  last recovered PCM1802 pair
- pcmValid  out  1  pulse: new PCM1802 pair
- sequenceOut  out  48  last recovered counter value
- sequenceValid  out  1  pulse: new counter value
- sequenceError  out  1  pulse: counter value != previous+1
- syncErrorCount  out  16  saturating count of bad-sync frames while locked
- seqErrorCount  out  16  saturating count of sequenceError pulses

## Operation
- Reset: all outputs 0, state HUNT, match index 0, firstCount flag set.
- Field f = dataIn[15:10]. Only words with dataValid=1 are "accepted".
- HUNT: index i (0..31). Accepted f == sync word i -> i+1. Mismatch -> i=1 if f == sync word 0, else 0. Match at i=31 -> LOCKED, position=32, firstCount set.
- LOCKED: position p (0..511) increments per accepted word, wraps 511->0.
  - p 0..31: compare f to sync word p; any mismatch marks frame bad. At p=31: bad -> syncErrorCount+1 (saturate 0xFFFF), missRun+1; good -> missRun=0. missRun reaching MISS_LIMIT -> HUNT, i=0, locked=0, missRun=0.
  - p 32/33: adcLeft[11:6]/[5:0]; p 34/35: adcRight[11:6]/[5:0]. Outputs update together after p=35.
  - p 36,37,46,47: reserved, ignored.
  - p 38..41: pcmLeft [23:18],[17:12],[11:6],[5:0]; p 42..45: pcmRight same order. Outputs update together after p=45.
  - p 48..511: block offset o=(p-48) mod 8 carries counter bits [6o+5:6o]; block complete at o=7 (58 blocks/frame).
- Counter check at block completion: if firstCount, accept, clear flag, no error. Else compare with (sequenceOut+1) mod 2^48; mismatch -> sequenceError, seqErrorCount+1 (saturate). sequenceOut always takes the received value (resynchronises).
- Continuity spans frame boundaries: first block of a frame = last block of previous frame +1.
- Shadow registers assemble fields; published outputs change only on completion, never partially.
- rfOut updates on every accepted word regardless of state.

## Timing
- All outputs registered; latency 1 cycle from accepting the completing word (p=35, 45, block o=7, sync match i=31, p=0).
- Pulses (frameStart, adcValid, pcmValid, sequenceValid, sequenceError) high exactly one cycle; sequenceError coincident with its sequenceValid.
- locked rises 1 cycle after 32nd matching word; falls 1 cycle after p=31 of the MISS_LIMIT-th bad frame.
- dataValid low: state, position, shadows and pulses frozen/deasserted; resume on next valid word, no loss.
- nReset asserted mid-frame: immediate return to reset values; relock requires full sync.

## Test plan
- Feed clean generator-format stream, counter starting 0x000000000000 -> locked 1 cycle after word 31; first frame sequenceValid x58 with values 0..57; sequenceError never; frameStart once per 512 words from frame 2.
- ADC L=0xABC, R=0x123; PCM L=0x800001, R=0x7FFFFF -> adcValid pulse with those values after p=35, pcmValid after p=45.
- Corrupt counter block value 100 to 105 once -> sequenceError at that block and at next (106 expected, 101 seen), seqErrorCount=2, sequenceOut tracks received values.
- Flip one sync word in two consecutive frames (MISS_LIMIT=2) -> syncErrorCount 1 then 2, locked drops after second p=31; clean stream relocks after 32 words.
- Stream begins at p=200 and includes partial-pattern prefix (sync words 0..5 then junk) -> no false lock; lock at next true sync.
- Toggle dataValid low every other cycle -> identical decoded values/counts as continuous run; assert nReset at p=40 -> all outputs 0, locked 0.

Source files
------------

// File: rtl/frame_decoder.sv
// Receive-side frame decoder: locks to the 512-word capture frame using the 32-word sync field
// and recovers ADC128 / PCM1802 audio, the 48-bit sequence counter and the RF pass-through.
module frame_decoder #(
    parameter logic [191:0] SYNC_PATTERN = 192'hDDDF20251015DDDF20251015DDDF20251016FEDCBA987654,
    parameter int unsigned  MISS_LIMIT   = 2
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [15:0] dataIn,
    input  logic        dataValid,
    output logic [9:0]  rfOut,
    output logic        locked,
    output logic        frameStart,
    output logic [11:0] adcLeft,
    output logic [11:0] adcRight,
    output logic        adcValid,
    output logic [23:0] pcmLeft,
    output logic [23:0] pcmRight,
    output logic        pcmValid,
    output logic [47:0] sequenceOut,
    output logic        sequenceValid,
    output logic        sequenceError,
    output logic [15:0] syncErrorCount,
    output logic [15:0] seqErrorCount
);
    typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

    function automatic logic [5:0] sync_word(input logic [4:0] k);
        logic [7:0] base;
        base = {1'b0, k, 2'b00} + {2'b00, k, 1'b0};
        return SYNC_PATTERN[base +: 6];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  hunt_idx_q, hunt_idx_d;
    logic [8:0]  pos_q, pos_d;
    logic        frame_bad_q, frame_bad_d;
    logic [3:0]  miss_run_q, miss_run_d;
    logic        first_count_q, first_count_d;
    logic [9:0]  rf_q, rf_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
    logic        adc_valid_q, adc_valid_d;
    logic [23:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
    logic        pcm_valid_q, pcm_valid_d;
    logic [47:0] seq_out_q, seq_out_d;
    logic        seq_valid_q, seq_valid_d;
    logic        seq_err_q, seq_err_d;
    logic [15:0] sync_err_cnt_q, sync_err_cnt_d;
    logic [15:0] seq_err_cnt_q, seq_err_cnt_d;
    logic [11:0] adc_l_sh_q, adc_l_sh_d;
    logic [5:0]  adc_r_sh_q, adc_r_sh_d;
    logic [23:0] pcm_l_sh_q, pcm_l_sh_d;
    logic [17:0] pcm_r_sh_q, pcm_r_sh_d;
    logic [41:0] seq_sh_q, seq_sh_d;

    logic [5:0]  field_s;
    logic [5:0]  exp_word_s;
    logic        word_match_s;
    logic        frame_bad_s;
    logic [3:0]  miss_next_s;
    logic [47:0] seq_rx_s;
    logic [47:0] seq_inc_s;

    // Next-state decode: hunting, sync checking, field assembly and counter continuity.
    always_comb begin
        field_s        = dataIn[15:10];
        exp_word_s     = sync_word((state_q == ST_LOCKED) ? pos_q[4:0] : hunt_idx_q);
        word_match_s   = (field_s == exp_word_s);
        frame_bad_s    = ((pos_q == 9'd0) ? 1'b0 : frame_bad_q) | ~word_match_s;
        miss_next_s    = miss_run_q + 4'd1;
        seq_rx_s       = {field_s, seq_sh_q};
        seq_inc_s      = seq_out_q + 48'd1;

        state_d        = state_q;
        hunt_idx_d     = hunt_idx_q;
        pos_d          = pos_q;
        frame_bad_d    = frame_bad_q;
        miss_run_d     = miss_run_q;
        first_count_d  = first_count_q;
        rf_d           = rf_q;
        frame_start_d  = 1'b0;
        adc_l_d        = adc_l_q;
        adc_r_d        = adc_r_q;
        adc_valid_d    = 1'b0;
        pcm_l_d        = pcm_l_q;
        pcm_r_d        = pcm_r_q;
        pcm_valid_d    = 1'b0;
        seq_out_d      = seq_out_q;
        seq_valid_d    = 1'b0;
        seq_err_d      = 1'b0;
        sync_err_cnt_d = sync_err_cnt_q;
        seq_err_cnt_d  = seq_err_cnt_q;
        adc_l_sh_d     = adc_l_sh_q;
        adc_r_sh_d     = adc_r_sh_q;
        pcm_l_sh_d     = pcm_l_sh_q;
        pcm_r_sh_d     = pcm_r_sh_q;
        seq_sh_d       = seq_sh_q;

        if (dataValid) begin
            rf_d = dataIn[9:0];
            case (state_q)
                ST_HUNT: begin
                    if (word_match_s) begin
                        if (hunt_idx_q == 5'd31) begin
                            state_d       = ST_LOCKED;
                            hunt_idx_d    = 5'd0;
                            pos_d         = 9'd32;
                            first_count_d = 1'b1;
                            miss_run_d    = 4'd0;
                        end else begin
                            hunt_idx_d = hunt_idx_q + 5'd1;
                        end
                    end else if (field_s == sync_word(5'd0)) begin
                        // A broken match may itself be the start of the real pattern.
                        hunt_idx_d = 5'd1;
                    end else begin
                        hunt_idx_d = 5'd0;
                    end
                end
                ST_LOCKED: begin
                    pos_d = pos_q + 9'd1;
                    if (pos_q < 9'd32) begin
                        frame_bad_d   = frame_bad_s;
                        frame_start_d = (pos_q == 9'd0);
                        if (pos_q == 9'd31) begin
                            if (frame_bad_s) begin
                                sync_err_cnt_d = sat_inc16(sync_err_cnt_q);
                                if (miss_next_s >= MISS_LIM) begin
                                    state_d    = ST_HUNT;
                                    hunt_idx_d = 5'd0;
                                    miss_run_d = 4'd0;
                                end else begin
                                    miss_run_d = miss_next_s;
                                end
                            end else begin
                                miss_run_d = 4'd0;
                            end
                        end else begin
                            miss_run_d = miss_run_q;
                        end
                    end else if (pos_q < 9'd48) begin
                        // Positions 32..47 map onto pos_q[3:0] = 0..15.
                        case (pos_q[3:0])
                            4'd0:  adc_l_sh_d[11:6]  = field_s;
                            4'd1:  adc_l_sh_d[5:0]   = field_s;
                            4'd2:  adc_r_sh_d        = field_s;
                            4'd3: begin
                                adc_l_d     = adc_l_sh_q;
                                adc_r_d     = {adc_r_sh_q, field_s};
                                adc_valid_d = 1'b1;
                            end
                            4'd6:  pcm_l_sh_d[23:18] = field_s;
                            4'd7:  pcm_l_sh_d[17:12] = field_s;
                            4'd8:  pcm_l_sh_d[11:6]  = field_s;
                            4'd9:  pcm_l_sh_d[5:0]   = field_s;
                            4'd10: pcm_r_sh_d[17:12] = field_s;
                            4'd11: pcm_r_sh_d[11:6]  = field_s;
                            4'd12: pcm_r_sh_d[5:0]   = field_s;
                            4'd13: begin
                                pcm_l_d     = pcm_l_sh_q;
                                pcm_r_d     = {pcm_r_sh_q, field_s};
                                pcm_valid_d = 1'b1;
                            end
                            default: adc_valid_d = 1'b0;
                        endcase
                    end else begin
                        case (pos_q[2:0])
                            3'd0: seq_sh_d[5:0]   = field_s;
                            3'd1: seq_sh_d[11:6]  = field_s;
                            3'd2: seq_sh_d[17:12] = field_s;
                            3'd3: seq_sh_d[23:18] = field_s;
                            3'd4: seq_sh_d[29:24] = field_s;
                            3'd5: seq_sh_d[35:30] = field_s;
                            3'd6: seq_sh_d[41:36] = field_s;
                            default: begin
                                seq_out_d   = seq_rx_s;
                                seq_valid_d = 1'b1;
                                if (first_count_q) begin
                                    first_count_d = 1'b0;
                                end else if (seq_rx_s != seq_inc_s) begin
                                    seq_err_d     = 1'b1;
                                    seq_err_cnt_d = sat_inc16(seq_err_cnt_q);
                                end else begin
                                    seq_err_d = 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else begin
            rf_d = rf_q;
        end
    end

    // State, shadow and published-output registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q        <= ST_HUNT;
            hunt_idx_q     <= 5'd0;
            pos_q          <= 9'd0;
            frame_bad_q    <= 1'b0;
            miss_run_q     <= 4'd0;
            first_count_q  <= 1'b1;
            rf_q           <= 10'd0;
            frame_start_q  <= 1'b0;
            adc_l_q        <= 12'd0;
            adc_r_q        <= 12'd0;
            adc_valid_q    <= 1'b0;
            pcm_l_q        <= 24'd0;
            pcm_r_q        <= 24'd0;
            pcm_valid_q    <= 1'b0;
            seq_out_q      <= 48'd0;
            seq_valid_q    <= 1'b0;
            seq_err_q      <= 1'b0;
            sync_err_cnt_q <= 16'd0;
            seq_err_cnt_q  <= 16'd0;
            adc_l_sh_q     <= 12'd0;
            adc_r_sh_q     <= 6'd0;
            pcm_l_sh_q     <= 24'd0;
            pcm_r_sh_q     <= 18'd0;
            seq_sh_q       <= 42'd0;
        end else begin
            state_q        <= state_d;
            hunt_idx_q     <= hunt_idx_d;
            pos_q          <= pos_d;
            frame_bad_q    <= frame_bad_d;
            miss_run_q     <= miss_run_d;
            first_count_q  <= first_count_d;
            rf_q           <= rf_d;
            frame_start_q  <= frame_start_d;
            adc_l_q        <= adc_l_d;
            adc_r_q        <= adc_r_d;
            adc_valid_q    <= adc_valid_d;
            pcm_l_q        <= pcm_l_d;
            pcm_r_q        <= pcm_r_d;
            pcm_valid_q    <= pcm_valid_d;
            seq_out_q      <= seq_out_d;
            seq_valid_q    <= seq_valid_d;
            seq_err_q      <= seq_err_d;
            sync_err_cnt_q <= sync_err_cnt_d;
            seq_err_cnt_q  <= seq_err_cnt_d;
            adc_l_sh_q     <= adc_l_sh_d;
            adc_r_sh_q     <= adc_r_sh_d;
            pcm_l_sh_q     <= pcm_l_sh_d;
            pcm_r_sh_q     <= pcm_r_sh_d;
            seq_sh_q       <= seq_sh_d;
        end
    end

    assign rfOut          = rf_q;
    assign locked         = (state_q == ST_LOCKED);
    assign frameStart     = frame_start_q;
    assign adcLeft        = adc_l_q;
    assign adcRight       = adc_r_q;
    assign adcValid       = adc_valid_q;
    assign pcmLeft        = pcm_l_q;
    assign pcmRight       = pcm_r_q;
    assign pcmValid       = pcm_valid_q;
    assign sequenceOut    = seq_out_q;
    assign sequenceValid  = seq_valid_q;
    assign sequenceError  = seq_err_q;
    assign syncErrorCount = sync_err_cnt_q;
    assign seqErrorCount  = seq_err_cnt_q;

endmodule

// File: tb/tb_frame_decoder.sv
// Bench for frame_decoder: generator-format frames with randomized payloads, checked every cycle
// against a word-level reference model, plus literal expectations at key frame positions.
module tb_frame_decoder;
    localparam logic [191:0] PAT = 192'hDDDF20251015DDDF20251015DDDF20251016FEDCBA987654;
    localparam int MISS_LIMIT = 2;
    localparam longint unsigned NO_CORRUPT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        nReset = 1'b1;
    logic [15:0] dataIn = 16'd0;
    logic        dataValid = 1'b0;
    logic [9:0]  rfOut;
    logic        locked, frameStart, adcValid, pcmValid, sequenceValid, sequenceError;
    logic [11:0] adcLeft, adcRight;
    logic [23:0] pcmLeft, pcmRight;
    logic [47:0] sequenceOut;
    logic [15:0] syncErrorCount, seqErrorCount;

    frame_decoder #(.SYNC_PATTERN(PAT), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clock(clock), .nReset(nReset), .dataIn(dataIn), .dataValid(dataValid),
        .rfOut(rfOut), .locked(locked), .frameStart(frameStart),
        .adcLeft(adcLeft), .adcRight(adcRight), .adcValid(adcValid),
        .pcmLeft(pcmLeft), .pcmRight(pcmRight), .pcmValid(pcmValid),
        .sequenceOut(sequenceOut), .sequenceValid(sequenceValid), .sequenceError(sequenceError),
        .syncErrorCount(syncErrorCount), .seqErrorCount(seqErrorCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int sw[32];
    bit cmp_en = 1'b0;

    // reference model state
    bit              m_locked, m_bad, m_first;
    int              m_idx, m_pos, m_miss;
    longint unsigned m_adc_acc, m_pcm_acc, m_cnt_acc;
    logic [9:0]      e_rf;
    logic            e_fs, e_av, e_pv, e_sv, e_se;
    logic [11:0]     e_adcl, e_adcr;
    logic [23:0]     e_pcml, e_pcmr;
    logic [47:0]     e_seq;
    logic [15:0]     e_syncc, e_seqc;

    // stream generator settings
    int              g_adcl, g_adcr, g_pcml, g_pcmr, g_flip;
    longint unsigned g_base, g_corrupt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_bad = 1'b0; m_first = 1'b1;
        m_idx = 0; m_pos = 0; m_miss = 0;
        m_adc_acc = 0; m_pcm_acc = 0; m_cnt_acc = 0;
        e_rf = '0; e_fs = 1'b0; e_av = 1'b0; e_pv = 1'b0; e_sv = 1'b0; e_se = 1'b0;
        e_adcl = '0; e_adcr = '0; e_pcml = '0; e_pcmr = '0; e_seq = '0;
        e_syncc = '0; e_seqc = '0;
    endtask

    task automatic model_step(input logic [15:0] w);
        int f, p, o;
        logic [47:0] v, nxt;
        f = int'(w[15:10]);
        e_rf = w[9:0];
        if (!m_locked) begin
            if (f == sw[m_idx]) begin
                if (m_idx == 31) begin
                    m_locked = 1'b1; m_pos = 32; m_first = 1'b1; m_idx = 0;
                end else m_idx++;
            end else m_idx = (f == sw[0]) ? 1 : 0;
        end else begin
            p = m_pos;
            m_pos = (p + 1) % 512;
            if (p < 32) begin
                if (p == 0) begin m_bad = 1'b0; e_fs = 1'b1; end
                if (f != sw[p]) m_bad = 1'b1;
                if (p == 31) begin
                    if (m_bad) begin
                        if (e_syncc != 16'hFFFF) e_syncc = e_syncc + 16'd1;
                        m_miss++;
                        if (m_miss >= MISS_LIMIT) begin m_locked = 1'b0; m_idx = 0; m_miss = 0; end
                    end else m_miss = 0;
                end
            end else if (p < 36) begin
                m_adc_acc = (m_adc_acc << 6) | longint'(f);
                if (p == 35) begin
                    e_adcl = 12'(m_adc_acc >> 12); e_adcr = 12'(m_adc_acc); e_av = 1'b1;
                end
            end else if (p >= 38 && p < 46) begin
                m_pcm_acc = (m_pcm_acc << 6) | longint'(f);
                if (p == 45) begin
                    e_pcml = 24'(m_pcm_acc >> 24); e_pcmr = 24'(m_pcm_acc); e_pv = 1'b1;
                end
            end else if (p >= 48) begin
                o = (p - 48) % 8;
                if (o == 0) m_cnt_acc = 0;
                m_cnt_acc = m_cnt_acc | (longint'(f) << (6 * o));
                if (o == 7) begin
                    v = 48'(m_cnt_acc);
                    nxt = e_seq + 48'd1;
                    if (m_first) m_first = 1'b0;
                    else if (v != nxt) begin
                        e_se = 1'b1;
                        if (e_seqc != 16'hFFFF) e_seqc = e_seqc + 16'd1;
                    end
                    e_seq = v; e_sv = 1'b1;
                end
            end
        end
    endtask

    // Reference model advances on each accepted word; reset is asynchronous like the DUT.
    always @(posedge clock or negedge nReset) begin
        if (!nReset) model_reset();
        else begin
            e_fs = 1'b0; e_av = 1'b0; e_pv = 1'b0; e_sv = 1'b0; e_se = 1'b0;
            if (dataValid) model_step(dataIn);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("rfOut", rfOut, e_rf);
            chk("locked", locked, m_locked);
            chk("frameStart", frameStart, e_fs);
            chk("adcLeft", adcLeft, e_adcl);
            chk("adcRight", adcRight, e_adcr);
            chk("adcValid", adcValid, e_av);
            chk("pcmLeft", pcmLeft, e_pcml);
            chk("pcmRight", pcmRight, e_pcmr);
            chk("pcmValid", pcmValid, e_pv);
            chk("sequenceOut", sequenceOut, e_seq);
            chk("sequenceValid", sequenceValid, e_sv);
            chk("sequenceError", sequenceError, e_se);
            chk("syncErrorCount", syncErrorCount, e_syncc);
            chk("seqErrorCount", seqErrorCount, e_seqc);
        end
    end

    function automatic logic [5:0] gen_field(input int p);
        longint unsigned v;
        int b, o;
        if (p < 32) return (p == g_flip) ? 6'(sw[p] ^ 1) : 6'(sw[p]);
        if (p < 48) begin
            case (p)
                32: return 6'(g_adcl >> 6);
                33: return 6'(g_adcl);
                34: return 6'(g_adcr >> 6);
                35: return 6'(g_adcr);
                38: return 6'(g_pcml >> 18);
                39: return 6'(g_pcml >> 12);
                40: return 6'(g_pcml >> 6);
                41: return 6'(g_pcml);
                42: return 6'(g_pcmr >> 18);
                43: return 6'(g_pcmr >> 12);
                44: return 6'(g_pcmr >> 6);
                45: return 6'(g_pcmr);
                default: return 6'($urandom);
            endcase
        end
        b = (p - 48) / 8;
        o = (p - 48) % 8;
        v = g_base + longint'(b);
        if (v == g_corrupt) v = v + 5;
        return 6'(v >> (6 * o));
    endfunction

    task automatic send(input logic [5:0] f);
        dataIn = {f, 10'($urandom)};
        dataValid = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic idle();
        dataIn = 16'($urandom);
        dataValid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic randomize_payload();
        g_adcl = int'($urandom_range(0, 4095));
        g_adcr = int'($urandom_range(0, 4095));
        g_pcml = int'($urandom_range(0, 24'hFFFFFF));
        g_pcmr = int'($urandom_range(0, 24'hFFFFFF));
    endtask

    task automatic hook(input int tag, input int p);
        case (tag)
            1: begin
                if (p == 30) begin @(negedge clock); chk("lock_before_w31", locked, 0); end
                else if (p == 31) begin @(negedge clock); chk("lock_after_w31", locked, 1); end
                else if (p == 35) begin
                    @(negedge clock);
                    chk("adc_pulse", adcValid, 1);
                    chk("adc_left_lit", adcLeft, 12'hABC);
                    chk("adc_right_lit", adcRight, 12'h123);
                end else if (p == 45) begin
                    @(negedge clock);
                    chk("pcm_pulse", pcmValid, 1);
                    chk("pcm_left_lit", pcmLeft, 24'h800001);
                    chk("pcm_right_lit", pcmRight, 24'h7FFFFF);
                end else if (p == 55) begin
                    @(negedge clock);
                    chk("seq_first_valid", sequenceValid, 1);
                    chk("seq_first_val", sequenceOut, 0);
                end else if (p == 511) begin
                    @(negedge clock);
                    chk("seq_last_val", sequenceOut, 57);
                    chk("seq_err_none", seqErrorCount, 0);
                end
            end
            2: begin
                if (p == 0) begin @(negedge clock); chk("frame_start_lit", frameStart, 1); end
                else if (p == 391) begin
                    @(negedge clock);
                    chk("seq_corrupt_err", sequenceError, 1);
                    chk("seq_corrupt_val", sequenceOut, 105);
                end else if (p == 399) begin
                    @(negedge clock);
                    chk("seq_resync_err", sequenceError, 1);
                    chk("seq_resync_val", sequenceOut, 101);
                end else if (p == 511) begin
                    @(negedge clock);
                    chk("seq_err_count2", seqErrorCount, 2);
                    chk("seq_frame2_last", sequenceOut, 115);
                end
            end
            3: if (p == 31) begin
                @(negedge clock);
                chk("sync_err_cnt1", syncErrorCount, 1);
                chk("lock_held_1miss", locked, 1);
            end
            4: if (p == 31) begin
                @(negedge clock);
                chk("sync_err_cnt2", syncErrorCount, 2);
                chk("lock_drop_2miss", locked, 0);
            end
            5: begin
                if (p == 30) begin @(negedge clock); chk("relock_pre", locked, 0); end
                else if (p == 31) begin @(negedge clock); chk("relock_w31", locked, 1); end
            end
            8: if (p == 40) begin
                dataValid = 1'b0;
                nReset = 1'b0;
                #1;
                chk("rst_locked", locked, 0);
                chk("rst_seq", sequenceOut, 0);
                chk("rst_adc", adcLeft, 0);
                chk("rst_pcm", pcmRight, 0);
                chk("rst_syncc", syncErrorCount, 0);
                chk("rst_seqc", seqErrorCount, 0);
                chk("rst_rf", rfOut, 0);
                @(posedge clock); #1;
                nReset = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic run_frame(input int p0, input int tag, input int gap);
        for (int p = p0; p < 512; p++) begin
            send(gen_field(p));
            hook(tag, p);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) idle();
        end
        g_base = g_base + 58;
    endtask

    initial begin
        logic [191:0] pat_v;
        pat_v = PAT;
        for (int k = 0; k < 32; k++) sw[k] = int'(pat_v[6 * k +: 6]);
        g_flip = -1;
        g_corrupt = NO_CORRUPT;
        #1 nReset = 1'b0;
        #1 cmp_en = 1'b1;
        chk("sync_word0", sw[0], 6'h14);
        chk("sync_word1", sw[1], 6'h19);
        chk("sync_word31", sw[31], 6'h37);
        repeat (2) @(posedge clock);
        #1 nReset = 1'b1;
        @(negedge clock);
        chk("reset_locked", locked, 0);
        chk("reset_seq", sequenceOut, 0);

        // partial sync prefix followed by junk, then a stream entering mid-frame
        for (int k = 0; k < 6; k++) send(6'(sw[k]));
        for (int k = 0; k < 10; k++) send(6'($urandom));
        @(negedge clock);
        chk("prefix_no_lock", locked, 0);
        randomize_payload();
        g_base = 1000;
        run_frame(200, 0, 0);

        g_base = 0;
        g_adcl = 12'hABC; g_adcr = 12'h123; g_pcml = 24'h800001; g_pcmr = 24'h7FFFFF;
        run_frame(0, 1, 0);

        randomize_payload();
        g_corrupt = 100;
        run_frame(0, 2, 2);
        g_corrupt = NO_CORRUPT;

        g_flip = 7;
        randomize_payload();
        run_frame(0, 3, 0);
        randomize_payload();
        run_frame(0, 4, 0);
        g_flip = -1;

        randomize_payload();
        run_frame(0, 5, 0);
        randomize_payload();
        run_frame(0, 0, 1);
        randomize_payload();
        run_frame(0, 0, 1);

        randomize_payload();
        run_frame(0, 8, 0);
        randomize_payload();
        run_frame(0, 5, 2);

        repeat (4) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
